// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, FSM states and flag bit positions shared by alu_seq and its iterative datapath.
package alu_seq_pkg;
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;
    localparam logic [3:0] OP_REMU = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;
endpackage

// File: rtl/alu_seq_iter.sv
// alu_seq_iter: iterative shift-add multiplier and (with ALU_SEQ_DIV_EN) restoring divider.
// done is asserted during the last iteration; result/dbz then carry that iteration's outcome.
module alu_seq_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef ALU_SEQ_DIV_EN
    input  logic             div,
    input  logic             rem_sel,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dbz
);
    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] a_r, b_r, acc, a_nx, b_nx, acc_nx;
    logic [CW-1:0]    cnt;
    logic             run;

    assign done = run && cnt == CW'(WIDTH - 1);

`ifdef ALU_SEQ_DIV_EN
    logic             div_r, rem_r;
    logic [WIDTH-1:0] rem, rem_nx;
    logic [WIDTH:0]   trial;
`endif

    always_comb begin
        acc_nx = acc + (b_r[0] ? a_r : '0);
        a_nx   = a_r << 1;
        b_nx   = b_r >> 1;
        result = acc_nx;
        dbz    = 1'b0;
`ifdef ALU_SEQ_DIV_EN
        // a_r shifts dividend bits out of the top and quotient bits in at the bottom
        trial  = {rem, a_r[WIDTH-1]} - {1'b0, b_r};
        rem_nx = trial[WIDTH] ? {rem[WIDTH-2:0], a_r[WIDTH-1]} : trial[WIDTH-1:0];
        if (div_r) begin
            a_nx   = {a_r[WIDTH-2:0], ~trial[WIDTH]};
            b_nx   = b_r;
            result = rem_r ? rem_nx : a_nx;
            dbz    = ~|b_r;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run <= 1'b0;
            cnt <= '0;
            a_r <= '0;
            b_r <= '0;
            acc <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
            a_r <= a;
            b_r <= b;
            acc <= '0;
        end else if (run) begin
            run <= !done;
            cnt <= cnt + 1'b1;
            a_r <= a_nx;
            b_r <= b_nx;
            acc <= acc_nx;
        end
    end

`ifdef ALU_SEQ_DIV_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= 1'b0;
            rem_r <= 1'b0;
            rem   <= '0;
        end else if (start) begin
            div_r <= div;
            rem_r <= rem_sel;
            rem   <= '0;
        end else if (run) begin
            rem   <= rem_nx;
        end
    end
`endif
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU with registered result/NZCV, iterative MUL and optional DIVU/REMU.
// Define ALU_SEQ_DIV_EN to build the divider; otherwise 1010/1011 act as unknown op codes.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] srcA_i,
    input  logic [WIDTH-1:0] srcB_i,
    input  logic [3:0]       ALUctrl_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] ALUresult_o,
    output logic [3:0]       NZCV_o
);
    localparam int SW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;

    state_t           state;
    logic             accept, iter_op, it_done, it_dbz, c, v;
    logic [WIDTH-1:0] sc_res, it_res;
    logic [WIDTH:0]   sum, diff;
    logic [SW-1:0]    shamt;
    logic [3:0]       sc_nzcv, it_nzcv;

    assign out_valid_o = state == S_DONE;
    assign in_ready_o  = state == S_IDLE || (state == S_DONE && out_ready_i);
    assign accept      = in_valid_i && in_ready_o;
    assign sum         = {1'b0, srcA_i} + {1'b0, srcB_i};
    assign diff        = {1'b0, srcA_i} - {1'b0, srcB_i};
    assign shamt       = srcB_i[SW-1:0];
`ifdef ALU_SEQ_DIV_EN
    assign iter_op = ALUctrl_i inside {OP_MUL, OP_DIVU, OP_REMU};
`else
    assign iter_op = ALUctrl_i == OP_MUL;
`endif

    alu_seq_iter #(.WIDTH(WIDTH)) u_iter (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .start   (accept && iter_op),
`ifdef ALU_SEQ_DIV_EN
        .div     (ALUctrl_i != OP_MUL),
        .rem_sel (ALUctrl_i == OP_REMU),
`endif
        .a       (srcA_i),
        .b       (srcB_i),
        .done    (it_done),
        .result  (it_res),
        .dbz     (it_dbz)
    );

    always_comb begin
        sc_res = '0;
        c      = 1'b0;
        v      = 1'b0;
        case (ALUctrl_i)
            OP_AND:  sc_res = srcA_i & srcB_i;
            OP_OR:   sc_res = srcA_i | srcB_i;
            OP_NOR:  sc_res = ~(srcA_i | srcB_i);
            OP_NAND: sc_res = ~(srcA_i & srcB_i);
            OP_SLL:  sc_res = srcA_i << shamt;
            OP_SRL:  sc_res = srcA_i >> shamt;
            OP_SRA:  sc_res = $unsigned($signed(srcA_i) >>> shamt);
            OP_SLT:  sc_res = WIDTH'($signed(srcA_i) < $signed(srcB_i));
            OP_ADD: begin
                sc_res = sum[M:0];
                c      = sum[WIDTH];
                v      = srcA_i[M] == srcB_i[M] && sum[M] != srcA_i[M];
            end
            OP_SUB: begin
                sc_res = diff[M:0];
                c      = ~diff[WIDTH];
                v      = srcA_i[M] != srcB_i[M] && diff[M] != srcA_i[M];
            end
            default: ;
        endcase
        sc_nzcv[F_N] = sc_res[M];
        sc_nzcv[F_Z] = ~|sc_res;
        sc_nzcv[F_C] = c;
        sc_nzcv[F_V] = v;
        it_nzcv[F_N] = it_res[M];
        it_nzcv[F_Z] = ~|it_res;
        it_nzcv[F_C] = 1'b0;
        it_nzcv[F_V] = it_dbz;
    end

    // an accept in DONE overwrites the held result on the same edge that retires it
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= S_IDLE;
            ALUresult_o <= '0;
            NZCV_o      <= '0;
        end else if (accept) begin
            state <= iter_op ? S_BUSY : S_DONE;
            if (!iter_op) begin
                ALUresult_o <= sc_res;
                NZCV_o      <= sc_nzcv;
            end
        end else if (state == S_BUSY && it_done) begin
            state       <= S_DONE;
            ALUresult_o <= it_res;
            NZCV_o      <= it_nzcv;
        end else if (state == S_DONE && out_ready_i) begin
            state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq at WIDTH=32 against a behavioural model.
// Expectations for 1010/1011 follow ALU_SEQ_DIV_EN.
module tb_alu_seq;
`ifdef ALU_SEQ_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clk = 1'b0, rst_i = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [3:0]  ctrl = 4'd0, nzcv;
    logic [31:0] srcA = '0, srcB = '0, result;
    int          total = 0, bad = 0;

    alu_seq #(.WIDTH(32)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .srcA_i      (srcA),
        .srcB_i      (srcB),
        .ALUctrl_i   (ctrl),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .ALUresult_o (result),
        .NZCV_o      (nzcv)
    );

    always #5 clk = ~clk;

    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        longint sa, sb, s;
        logic c, v;
        sa = $signed(a);
        sb = $signed(b);
        c = 1'b0;
        v = 1'b0;
        r = '0;
        lat = 1;
        case (op)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd12: r = ~(a | b);
            4'd13: r = ~(a & b);
            4'd3:  r = a << b[4:0];
            4'd4:  r = a >> b[4:0];
            4'd5:  r = 32'(sa >>> b[4:0]);
            4'd7:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd2: begin
                s = sa + sb;
                r = a + b;
                c = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
                v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            4'd6: begin
                s = sa - sb;
                r = a - b;
                c = a >= b;
                v = s > 64'sd2147483647 || s < -64'sd2147483648;
            end
            4'd8: begin
                r = 32'(64'(a) * 64'(b));
                lat = 33;
            end
            4'd10, 4'd11: if (DIV_EN) begin
                lat = 33;
                if (b == 0) begin
                    v = 1'b1;
                    r = (op == 4'd10) ? 32'hFFFF_FFFF : a;
                end else begin
                    r = (op == 4'd10) ? a / b : a % b;
                end
            end
            default: ;
        endcase
        f = {r[31], r == 0, c, v};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic [3:0] f, output int lat, output bit busy_rdy);
        int n = 0;
        @(negedge clk);
        ctrl = op;
        srcA = a;
        srcB = b;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        busy_rdy = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_rdy = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        r = result;
        f = nzcv;
    endtask

    task automatic test_reset;
        #2 rst_i = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_hs: valid/ready=%b want 01", {out_valid, in_ready});
        end
        total++;
        if ({result, nzcv} !== 36'h0) begin
            bad++;
            $display("FAIL reset_regs: got %h/%b want 00000000/0000", result, nzcv);
        end
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_release: valid/ready=%b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_add_sub_sra;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        bit          br;
        logic [3:0]  ops [4] = '{4'd2, 4'd6, 4'd6, 4'd5};
        logic [31:0] as  [4] = '{32'h7FFF_FFFF, 32'd5, 32'd7, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'h1, 32'd7, 32'd5, 32'd4};
        logic [31:0] er  [4] = '{32'h8000_0000, 32'hFFFF_FFFE, 32'h2, 32'hF800_0000};
        logic [3:0]  ef  [4] = '{4'b1001, 4'b1000, 4'b0010, 4'b1000};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], r, f, lat, br);
            total++;
            if ({r, f} !== {er[i], ef[i]}) begin
                bad++;
                $display("FAIL directed_%0d op=%b: got %h/%b want %h/%b", i, ops[i], r, f, er[i], ef[i]);
            end
            total++;
            if (lat !== 1) begin
                bad++;
                $display("FAIL directed_lat_%0d: got %0d want 1", i, lat);
            end
        end
    endtask

    task automatic test_mul;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        bit          br;
        run_op(4'd8, 32'h0001_0003, 32'h5, r, f, lat, br);
        total++;
        if ({r, f} !== {32'h0005_000F, 4'b0000}) begin
            bad++;
            $display("FAIL mul: got %h/%b want 0005000f/0000", r, f);
        end
        total++;
        if (lat !== 33) begin
            bad++;
            $display("FAIL mul_lat: got %0d want 33", lat);
        end
        total++;
        if (br !== 1'b0) begin
            bad++;
            $display("FAIL mul_busy_ready: in_ready seen high=%b want 0", br);
        end
    endtask

    task automatic test_div;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        bit          br;
`ifdef ALU_SEQ_DIV_EN
        logic [3:0]  ops [3] = '{4'd10, 4'd11, 4'd10};
        logic [31:0] as  [3] = '{32'd100, 32'd100, 32'h1234_5678};
        logic [31:0] bs  [3] = '{32'd7, 32'd7, 32'd0};
        logic [31:0] er  [3] = '{32'd14, 32'd2, 32'hFFFF_FFFF};
        logic [3:0]  ef  [3] = '{4'b0000, 4'b0000, 4'b1001};
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], as[i], bs[i], r, f, lat, br);
            total++;
            if ({r, f} !== {er[i], ef[i]}) begin
                bad++;
                $display("FAIL div_%0d: got %h/%b want %h/%b", i, r, f, er[i], ef[i]);
            end
            total++;
            if (lat !== 33) begin
                bad++;
                $display("FAIL div_lat_%0d: got %0d want 33", i, lat);
            end
        end
`else
        run_op(4'd10, 32'd100, 32'd7, r, f, lat, br);
        total++;
        if ({r, f} !== {32'h0, 4'b0100}) begin
            bad++;
            $display("FAIL div_disabled: got %h/%b want 00000000/0100", r, f);
        end
        total++;
        if (lat !== 1) begin
            bad++;
            $display("FAIL div_disabled_lat: got %0d want 1", lat);
        end
`endif
    endtask

    task automatic test_hold;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
        bit          br;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        run_op(4'd1, 32'h00F0_0F00, 32'h8000_000F, r, f, lat, br);
        total++;
        if ({r, f} !== {32'h80F0_0F0F, 4'b1000}) begin
            bad++;
            $display("FAIL hold_or: got %h/%b want 80f00f0f/1000", r, f);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({out_valid, in_ready, result, nzcv} !== {2'b10, 32'h80F0_0F0F, 4'b1000}) begin
                bad++;
                $display("FAIL hold_cycle_%0d: v/r=%b res=%h nzcv=%b want 10/80f00f0f/1000",
                         i, {out_valid, in_ready}, result, nzcv);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        ctrl = 4'd2;
        srcA = 32'd40;
        srcB = 32'd2;
        in_valid = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL hold_release_ready: got %b want 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        total++;
        if ({out_valid, result, nzcv} !== {1'b1, 32'd42, 4'b0000}) begin
            bad++;
            $display("FAIL hold_next: valid=%b res=%h nzcv=%b want 1/0000002a/0000", out_valid, result, nzcv);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b, er;
        logic [3:0]  op, ef;
        int          lat;
        logic [3:0]  sc_ops [9] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd12};
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            op = sc_ops[$urandom_range(0, 8)];
            a = $urandom;
            b = $urandom;
            ctrl = op;
            srcA = a;
            srcB = b;
            in_valid = 1'b1;
            model(op, a, b, er, ef, lat);
            @(posedge clk);
            #1;
            total++;
            if ({out_valid, result, nzcv} !== {1'b1, er, ef}) begin
                bad++;
                $display("FAIL b2b_%0d op=%b a=%h b=%h: valid=%b got %h/%b want %h/%b",
                         i, op, a, b, out_valid, result, nzcv, er, ef);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_random;
        logic [31:0] a, b, r, er;
        logic [3:0]  op, f, ef;
        int          lat, elat;
        bit          br;
        out_ready = 1'b1;
        for (int i = 0; i < 24; i++) begin
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom);
            model(op, a, b, er, ef, elat);
            run_op(op, a, b, r, f, lat, br);
            total++;
            if ({r, f, lat} !== {er, ef, elat}) begin
                bad++;
                $display("FAIL rand_%0d op=%b a=%h b=%h: got %h/%b lat=%0d want %h/%b lat=%0d",
                         i, op, a, b, r, f, lat, er, ef, elat);
            end
        end
    endtask

    task automatic test_async_reset;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat, n;
        bit          br, seen;
        out_ready = 1'b1;
        n = 0;
        @(negedge clk);
        ctrl = 4'd8;
        srcA = 32'hDEAD_BEEF;
        srcB = 32'h1234_5677;
        in_valid = 1'b1;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2 rst_i = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready, result, nzcv} !== {2'b01, 32'h0, 4'b0000}) begin
            bad++;
            $display("FAIL async_reset: v/r=%b res=%h nzcv=%b want 01/00000000/0000",
                     {out_valid, in_ready}, result, nzcv);
        end
        #2 rst_i = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (out_valid || !in_ready) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL async_abort: aborted op presented or ready dropped (flag=%b want 0)", seen);
        end
        run_op(4'd2, 32'd2, 32'd3, r, f, lat, br);
        total++;
        if ({r, f, lat} !== {32'd5, 4'b0000, 1}) begin
            bad++;
            $display("FAIL post_reset_add: got %h/%b lat=%0d want 00000005/0000 lat=1", r, f, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add_sub_sra();
        test_mul();
        test_div();
        test_hold();
        test_back_to_back();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
